// File: rtl/mem_pkg.sv
// Shared access codes, FSM states and small decode helpers for the data memory controller.
package mem_pkg;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] SW  = 3'b001;
  localparam logic [2:0] LB  = 3'b010;
  localparam logic [2:0] SB  = 3'b011;
  localparam logic [2:0] LBU = 3'b110;

  typedef enum logic [2:0] {
    MODE_LW  = LW,
    MODE_SW  = SW,
    MODE_LB  = LB,
    MODE_SB  = SB,
    MODE_LBU = LBU
  } req_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_CAP0,
    ST_ACC1,
    ST_CAP1,
    ST_RESP
  } state_e;

  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode == LW) || (mode == SW) || (mode == LB) || (mode == SB) || (mode == LBU);
  endfunction

  function automatic logic mode_is_store(input logic [2:0] mode);
    return (mode == SW) || (mode == SB);
  endfunction

  // Only full-word accesses can straddle a word boundary; byte accesses never split.
  function automatic logic mode_splits(input logic [2:0] mode, input logic [1:0] off);
    return ((mode == LW) || (mode == SW)) && (off != 2'd0);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store shifting, byte enables and load extraction/extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  off,
  input  logic        beat,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [4:0] lo_sh;
  logic [5:0] hi_sh;
  logic [7:0] lane_byte;

  // Lane shifts, enables and load assembly for the current beat.
  always_comb begin
    lo_sh   = {off, 3'b000};
    hi_sh   = 6'd32 - {1'b0, lo_sh};
    be      = 4'b0000;
    wdata   = st_data;
    ld_data = 32'h0;

    case (off)
      2'd0:    lane_byte = ld_lo[7:0];
      2'd1:    lane_byte = ld_lo[15:8];
      2'd2:    lane_byte = ld_lo[23:16];
      default: lane_byte = ld_lo[31:24];
    endcase

    case (mode)
      LW, SW: begin
        if (beat) begin
          // Second beat carries the bytes that spilled past the first word.
          be    = 4'b1111 >> (3'd4 - {1'b0, off});
          wdata = st_data >> hi_sh;
        end else begin
          be    = 4'b1111 << off;
          wdata = st_data << lo_sh;
        end
        // Little-endian assembly; with off=0 the upper-word term shifts out entirely.
        ld_data = (ld_lo >> lo_sh) | (ld_hi << hi_sh);
      end
      SB: begin
        be    = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
      end
      LB: begin
        be      = 4'b0001 << off;
        ld_data = {{24{lane_byte[7]}}, lane_byte};
      end
      LBU: begin
        be      = 4'b0001 << off;
        ld_data = {24'h0, lane_byte};
      end
      default: begin
        be      = 4'b0000;
        ld_data = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: one request at a time, splits misaligned words into two beats.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | first memory beat issued (word address)
// CAP0  | first read word returns on mem_rdata
// ACC1  | second beat issued (word address + 1) for misaligned LW/SW
// CAP1  | second read word returns; load result assembled
// RESP  | rsp_valid for one cycle, then back to IDLE
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_mode,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  state_e                state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic [MEM_ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  in_acc;
  logic                  beat1;
  logic [31:0]           ld_lo;
  logic [3:0]            al_be;
  logic [31:0]           al_wdata;
  logic [31:0]           al_ld_data;

  assign beat1 = (state_q == ST_ACC1) || (state_q == ST_CAP1);
  assign ld_lo = (state_q == ST_CAP1) ? lo_q : mem_rdata;

  mem_lane_align u_align (
    .mode    (mode_q),
    .off     (off_q),
    .beat    (beat1),
    .st_data (wdata_q),
    .ld_lo   (ld_lo),
    .ld_hi   (mem_rdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .ld_data (al_ld_data)
  );

  // State and captured-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'b000;
      waddr_q <= '0;
      off_q   <= 2'd0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state sequencing and request/result capture.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mode_d  = req_mode;
          waddr_d = req_addr[MEM_ADDR_W+1:2];
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          if (mode_legal(req_mode)) begin
            err_d   = 1'b0;
            state_d = ST_ACC0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACC0: begin
        if (!mode_is_store(mode_q)) begin
          state_d = ST_CAP0;
        end else if (mode_splits(mode_q, off_q)) begin
          state_d = ST_ACC1;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_CAP0: begin
        if (mode_splits(mode_q, off_q)) begin
          lo_d    = mem_rdata;
          state_d = ST_ACC1;
        end else begin
          rdata_d = al_ld_data;
          state_d = ST_RESP;
        end
      end
      ST_ACC1: begin
        state_d = mode_is_store(mode_q) ? ST_RESP : ST_CAP1;
      end
      ST_CAP1: begin
        rdata_d = al_ld_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; everything except req_ready is zero outside its active state.
  always_comb begin
    in_acc    = (state_q == ST_ACC0) || (state_q == ST_ACC1);
    req_ready = (state_q == ST_IDLE);
    mem_en    = in_acc;
    mem_we    = in_acc && mode_is_store(mode_q);
    mem_be    = in_acc ? al_be : 4'b0000;
    mem_wdata = mem_we ? al_wdata : 32'h0;
    mem_addr  = '0;
    if (state_q == ST_ACC0) begin
      mem_addr = waddr_q;
    end else if (state_q == ST_ACC1) begin
      mem_addr = waddr_q + MEM_ADDR_W'(1);
    end
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;
    rsp_err   = (state_q == ST_RESP) && err_q;
  end

endmodule
